dmem_io: RTL and testbench
==========================

Name: dmem_io

Overview:
- Data-side memory stage directly downstream of the single-cycle MIPS core.
- Consumes the core's aluout (address), writedata, memwrite and store-size controls; returns readdata in the same cycle.
- Contains word-organised data RAM with byte/halfword store lanes, plus a small memory-mapped I/O page: LED register, free-running cycle counter, down-count timer with sticky IRQ, and a status register.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; power of two.
- LED_W, 8, width of the LED output register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- memwrite  input  1  store strobe for the current cycle.
- size  input  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- addr  input  32  byte address (core aluout).
- writedata  input  32  store data, right-justified for sub-word stores.
- readdata  output  32  full aligned word at addr; combinational. Sub-word extraction/extension stays in the core datapath.
- leds  output  LED_W  LED register contents.
- irq  output  1  timer-expired sticky flag.
- misalign  output  1  sticky misaligned-store flag.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low.
- Reset clears leds, irq, misalign, cycle counter and timer to 0. RAM contents are not reset.
- Decode:
  - addr[31:16] == 16'hFFFF selects the I/O page.
  - Any other address selects RAM at word index addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Reads: combinational, zero latency; readdata tracks addr every cycle regardless of memwrite.
- RAM stores commit at the rising edge when memwrite=1. Byte lanes are little-endian: lane n = bits 8n+7:8n.
  - Word: requires addr[1:0]=00; writes all 4 lanes.
  - Half: requires addr[0]=0; writes writedata[15:0] to lanes {1,0} (addr[1]=0) or {3,2} (addr[1]=1).
  - Byte: writes writedata[7:0] to lane addr[1:0].
  - Misaligned store: RAM is left unchanged and misalign is set at that edge.
- I/O registers (word offset = addr[15:0]):
  - 0x0000 LED: read {zero-pad, leds}; word store loads writedata[LED_W-1:0].
  - 0x0004 CYCLE: increments by 1 every cycle, wrapping 0xFFFFFFFF->0. A word store loads writedata at that edge; increments resume the following cycle.
  - 0x0008 TIMER: a word store loads writedata. Otherwise, if nonzero, it decrements by 1 each cycle. On the edge where it goes 1->0, irq is set. A load of 0 never sets irq. A store during an active countdown overrides the decrement.
  - 0x000C STATUS: read {30'b0, misalign, irq}. A word store with writedata[0]=1 clears irq; writedata[1]=1 clears misalign.
  - Set-vs-clear in the same cycle: set wins.
- I/O restrictions:
  - Sub-word stores to the I/O page are ignored; misalign is not set.
  - Unmapped I/O offsets read 0; stores to them are ignored.
  - Misaligned word stores to the I/O page are ignored and set misalign.
- Reset asserted mid-countdown aborts the countdown immediately; irq stays 0.

Optional Feature:
- Macro: DMEM_IO_TIMER_EN.
- Defined: TIMER register and the irq set source are present as specified above.
- Undefined:
  - offset 0x0008 reads 0 and ignores stores;
  - irq is tied to 0;
  - STATUS bit0 reads 0.

Test Plan:
- Reset low, then high; read 0xFFFF0000 and 0xFFFF000C -> both 0; leds=0, irq=0, misalign=0.
- Word store 0x11223344 at 0x10; byte store 0xAA at 0x12; half store 0xBEEF at 0x10 -> read 0x10 gives 0x11AABEEF.
- Half store at 0x21 and word store at 0x22 -> RAM word 0x20 unchanged, misalign=1. Then STATUS write 0x2 -> misalign=0.
- Word store at 0x10 + DEPTH_WORDS*4 (0x110 for 64) -> read 0x10 returns the stored value (wrap).
- TIMER write 3 -> irq rises exactly 3 edges later; TIMER write 0 leaves irq=0. STATUS write 1 on the same edge the timer expires -> irq=1 (set wins).
- CYCLE write 0xFFFFFFFE, read on the next two cycles -> 0xFFFFFFFF, then 0x00000000. Assert reset mid-count -> CYCLE=0 and TIMER=0 asynchronously.

Source files
------------

// File: rtl/dmem_io.sv
// dmem_io: data-side memory stage for the single-cycle MIPS core.
// Word-organised data RAM with byte/halfword store lanes, plus an I/O page
// at 0xFFFF_xxxx holding LED, CYCLE, TIMER and STATUS registers.
// Optional feature macro: DMEM_IO_TIMER_EN (TIMER register and irq source).
// Without it, offset 0x0008 reads 0 and ignores stores, and irq is tied low.
module dmem_io #(
  parameter int DEPTH_WORDS = 64,
  parameter int LED_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [1:0]       size,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] leds,
  output logic             irq,
  output logic             misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // storage
  logic [31:0]      mem_r [DEPTH_WORDS];
  logic [LED_W-1:0] leds_r;
  logic [31:0]      cycle_r;
  logic             misalign_r;
`ifdef DMEM_IO_TIMER_EN
  logic [31:0]      timer_r;
  logic             irq_r;
  logic             wr_timer_s;
  logic             irq_set_s;
`endif

  // decode
  logic [AW-1:0] word_idx_s;
  logic          io_sel_s;
  logic          word_sz_s;
  logic          misaligned_s;
  logic [3:0]    be_s;
  logic [31:0]   wlane_s;
  logic          ram_we_s;
  logic          io_wr_s;
  logic          misalign_set_s;
  logic          wr_led_s;
  logic          wr_cycle_s;
  logic          wr_status_s;
  logic          irq_s;
  logic [31:0]   led_rd_s;
  logic [31:0]   io_rd_s;

  assign word_idx_s = addr[AW+1:2];
  assign io_sel_s   = (addr[31:16] == 16'hFFFF);

  // Size decode: lane enables, lane-replicated store data and alignment check
  always_comb begin
    word_sz_s    = 1'b0;
    misaligned_s = 1'b0;
    be_s         = 4'b0000;
    wlane_s      = writedata;
    case (size)
      2'b01: begin
        misaligned_s = addr[0];
        be_s         = addr[1] ? 4'b1100 : 4'b0011;
        wlane_s      = {2{writedata[15:0]}};
      end
      2'b10: begin
        be_s    = 4'b0001 << addr[1:0];
        wlane_s = {4{writedata[7:0]}};
      end
      default: begin
        // 2'b11 is treated as a word access
        word_sz_s    = 1'b1;
        misaligned_s = (addr[1:0] != 2'b00);
        be_s         = 4'b1111;
      end
    endcase
  end

  // Sub-word stores to the I/O page are silently dropped (no misalign),
  // misaligned word stores anywhere flag misalign.
  assign ram_we_s       = memwrite & ~io_sel_s & ~misaligned_s;
  assign io_wr_s        = memwrite & io_sel_s & word_sz_s & ~misaligned_s;
  assign misalign_set_s = memwrite & misaligned_s & (~io_sel_s | word_sz_s);
  assign wr_led_s       = io_wr_s & (addr[15:0] == 16'h0000);
  assign wr_cycle_s     = io_wr_s & (addr[15:0] == 16'h0004);
  assign wr_status_s    = io_wr_s & (addr[15:0] == 16'h000C);

  // RAM store with per-lane enables; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
        end
      end
    end
  end

  // LED register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_r <= {LED_W{1'b0}};
    end else if (wr_led_s) begin
      leds_r <= writedata[LED_W-1:0];
    end
  end

  // Free-running cycle counter; a store overrides that cycle's increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_r <= 32'h0000_0000;
    end else if (wr_cycle_s) begin
      cycle_r <= writedata;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end

  // Sticky misalign flag; a set in the same cycle beats a STATUS clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_set_s | (misalign_r & ~(wr_status_s & writedata[1]));
    end
  end

`ifdef DMEM_IO_TIMER_EN
  assign wr_timer_s = io_wr_s & (addr[15:0] == 16'h0008);
  // Expiry is the 1->0 step of the countdown; a store that edge pre-empts it
  assign irq_set_s  = ~wr_timer_s & (timer_r == 32'd1);

  // Down-count timer; a store overrides the decrement
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_r <= 32'h0000_0000;
    end else if (wr_timer_s) begin
      timer_r <= writedata;
    end else if (timer_r != 32'h0000_0000) begin
      timer_r <= timer_r - 32'd1;
    end
  end

  // Sticky irq flag; a set in the same cycle beats a STATUS clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_set_s | (irq_r & ~(wr_status_s & writedata[0]));
    end
  end

  assign irq_s = irq_r;
`else
  assign irq_s = 1'b0;
`endif

  // I/O page read mux; unmapped offsets read zero
  always_comb begin
    led_rd_s              = {32{1'b0}};
    led_rd_s[LED_W-1:0]   = leds_r;
    case (addr[15:0])
      16'h0000: io_rd_s = led_rd_s;
      16'h0004: io_rd_s = cycle_r;
`ifdef DMEM_IO_TIMER_EN
      16'h0008: io_rd_s = timer_r;
`endif
      16'h000C: io_rd_s = {30'b0, misalign_r, irq_s};
      default:  io_rd_s = 32'h0000_0000;
    endcase
  end

  assign readdata = io_sel_s ? io_rd_s : mem_r[word_idx_s];
  assign leds     = leds_r;
  assign misalign = misalign_r;
  assign irq      = irq_s;

endmodule

// File: tb/tb_dmem_io.sv
// Directed self-checking bench for dmem_io (DEPTH_WORDS=64, LED_W=8).
module tb_dmem_io;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  leds;
  logic        irq;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_io #(.DEPTH_WORDS(64), .LED_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .size     (size),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .leds     (leds),
    .irq      (irq),
    .misalign (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // one store committed at the next rising edge; returns 1 time unit after it
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    addr      = a;
    writedata = d;
    size      = sz;
    memwrite  = 1'b1;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a);
    memwrite = 1'b0;
    addr     = a;
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    memwrite  = 1'b0;
    size      = 2'b00;
    addr      = 32'h0;
    writedata = 32'h0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", {24'h0, leds}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    peek(32'hFFFF0004);
    check("rst_cycle", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    peek(32'hFFFF0000);
    check("led_read0", readdata, 32'h0);
    peek(32'hFFFF000C);
    check("status_read0", readdata, 32'h0);

    // byte/half/word lanes
    store(32'h10, 32'h11223344, 2'b00);
    store(32'h12, 32'h000000AA, 2'b10);
    store(32'h10, 32'h0000BEEF, 2'b01);
    peek(32'h10);
    check("lanes", readdata, 32'h11AABEEF);
    store(32'h30, 32'hCAFEF00D, 2'b11);
    peek(32'h30);
    check("size11_word", readdata, 32'hCAFEF00D);
    store(32'h37, 32'h00000012, 2'b10);
    store(32'h34, 32'h00003456, 2'b01);
    store(32'h36, 32'h0000AB78, 2'b01);
    peek(32'h34);
    check("sub_lanes_hi", readdata, 32'hAB783456);

    // misaligned RAM stores
    store(32'h20, 32'h55667788, 2'b00);
    store(32'h21, 32'h0000FFFF, 2'b01);
    check("misalign_half", {31'h0, misalign}, 32'h1);
    store(32'h22, 32'h00000000, 2'b00);
    peek(32'h20);
    check("misalign_ram_kept", readdata, 32'h55667788);
    peek(32'hFFFF000C);
    check("status_misalign", readdata, 32'h2);
    store(32'hFFFF000C, 32'h2, 2'b00);
    check("misalign_clear", {31'h0, misalign}, 32'h0);

    // LED and I/O restrictions
    store(32'hFFFF0000, 32'h12345678, 2'b00);
    check("leds_out", {24'h0, leds}, 32'h78);
    peek(32'hFFFF0000);
    check("led_read", readdata, 32'h00000078);
    store(32'hFFFF0000, 32'h000000FF, 2'b01);
    check("io_half_ignored", {24'h0, leds}, 32'h78);
    check("io_half_no_misalign", {31'h0, misalign}, 32'h0);
    store(32'hFFFF0002, 32'h00000055, 2'b00);
    check("io_misalign_set", {31'h0, misalign}, 32'h1);
    check("io_misalign_leds", {24'h0, leds}, 32'h78);
    store(32'hFFFF000C, 32'h2, 2'b00);
    store(32'hFFFF0010, 32'hDEADBEEF, 2'b00);
    peek(32'hFFFF0010);
    check("unmapped_read", readdata, 32'h0);

    // address wrap
    store(32'h110, 32'h0BADF00D, 2'b00);
    peek(32'h10);
    check("wrap", readdata, 32'h0BADF00D);
    peek(32'hABCD0010);
    check("upper_ignored", readdata, 32'h0BADF00D);

    // cycle counter wrap
    store(32'hFFFF0004, 32'hFFFFFFFE, 2'b00);
    check("cycle_load", readdata, 32'hFFFFFFFE);
    @(posedge clk);
    #1;
    check("cycle_ff", readdata, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    check("cycle_wrap", readdata, 32'h0);

`ifdef DMEM_IO_TIMER_EN
    // countdown and expiry
    store(32'hFFFF0008, 32'd3, 2'b00);
    check("timer_load", readdata, 32'd3);
    check("irq_e0", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("timer_e1", readdata, 32'd2);
    check("irq_e1", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("irq_e2", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("irq_e3", {31'h0, irq}, 32'h1);
    check("timer_e3", readdata, 32'd0);
    peek(32'hFFFF000C);
    check("status_irq", readdata, 32'h1);
    store(32'hFFFF000C, 32'h1, 2'b00);
    check("irq_clear", {31'h0, irq}, 32'h0);
    store(32'hFFFF0008, 32'd0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check("timer_zero_noirq", {31'h0, irq}, 32'h0);
    // set beats clear on the expiry edge
    store(32'hFFFF0008, 32'd2, 2'b00);
    @(posedge clk);
    #1;
    store(32'hFFFF000C, 32'h1, 2'b00);
    check("set_wins", {31'h0, irq}, 32'h1);
    store(32'hFFFF000C, 32'h1, 2'b00);
    check("irq_clear2", {31'h0, irq}, 32'h0);
    // store overrides an active countdown
    store(32'hFFFF0008, 32'd100, 2'b00);
    @(posedge clk);
    #1;
    store(32'hFFFF0008, 32'd5, 2'b00);
    check("timer_override", readdata, 32'd5);
    // reset mid-countdown
    store(32'hFFFF0008, 32'd50, 2'b00);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("timer_async_rst", readdata, 32'h0);
`else
    store(32'hFFFF0008, 32'd3, 2'b00);
    repeat (4) @(posedge clk);
    #1;
    check("timer_absent_read", readdata, 32'h0);
    check("timer_absent_irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
`endif
    peek(32'hFFFF0004);
    check("cycle_async_rst", readdata, 32'h0);
    check("leds_async_rst", {24'h0, leds}, 32'h0);
    check("irq_async_rst", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("irq_after_rst", {31'h0, irq}, 32'h0);
    check("cycle_after_rst", readdata, 32'd4);
    peek(32'h10);
    check("ram_kept_rst", readdata, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
